// File: rtl/op_pkg.sv
// Shared types and constants for the integer-to-bfloat16 op unit.
// Latency: n/a (declarations only). Backpressure: n/a.
// Feature macro OP_INT2BF16_RNE_EN is consumed by op_bf16_pack.
package op_pkg;

    localparam logic [7:0]  BF16_BIAS = 8'd127;
    localparam logic [15:0] BF16_ZERO = 16'h0000;

    typedef enum logic [2:0] {
        IDLE,
        ABS,
        NORM,
        PACK,
        OUT
    } state_t;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] mant;
    } bf16_t;

endpackage

// File: rtl/op_bf16_pack.sv
// Packs a normalised magnitude (leading one at msb), exponent and sign into bfloat16.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// OP_INT2BF16_RNE_EN selects round-to-nearest-even; otherwise low bits are truncated.
module op_bf16_pack
    import op_pkg::*;
#(
    parameter int IN_W = 8
) (
    input  logic [IN_W-1:0] mag,
    input  logic [7:0]      exp,
    input  logic            sign,
    output bf16_t           word
);

    // Bits below the leading one, left-aligned; IN_W < 8 zero-pads on the right.
    logic [31:0] frac;
    logic [6:0]  mant;

    assign frac = 32'(mag[IN_W-2:0]) << (33 - IN_W);
    assign mant = frac[31:25];

`ifdef OP_INT2BF16_RNE_EN
    logic       guard;
    logic       sticky;
    logic       round_up;
    logic [7:0] mant_inc;
    logic       unused_bits;

    assign guard       = frac[24];
    assign sticky      = |frac[23:0];
    assign round_up    = guard && (sticky || mant[0]);
    assign mant_inc    = {1'b0, mant} + 8'(round_up);
    assign unused_bits = mag[IN_W-1];

    // A carry out of the mantissa bumps the exponent and leaves mant at zero.
    assign word = {sign, exp + 8'(mant_inc[7]), mant_inc[6:0]};
`else
    logic unused_bits;

    assign unused_bits = &{1'b0, mag[IN_W-1], frac[24:0]};
    assign word        = {sign, exp, mant};
`endif

endmodule

// File: rtl/op_int2bf16.sv
// Integer (IN_W bits, signed or unsigned) to bfloat16 op unit, normalising one bit per clock.
// Latency: accept at edge T gives STB after edge T+3+k (k = leading zeros), zero input after T+2.
// Backpressure: op_BUSY high from accept until result taken; STB held while output_module_BUSY.
// Optional rounding via OP_INT2BF16_RNE_EN (see op_bf16_pack).
module op_int2bf16
    import op_pkg::*;
#(
    parameter int IN_W   = 8,
    parameter int SIGNED = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] input_int,
    input  logic            op_input_STB,
    output logic            op_BUSY,
    output logic [15:0]     output_x,
    output logic            op_output_STB,
    input  logic            output_module_BUSY
);

    localparam logic [7:0] EXP_INIT = BF16_BIAS + 8'(IN_W - 1);

    state_t          state;
    state_t          state_nxt;
    logic [IN_W-1:0] mag;
    logic [7:0]      exp;
    logic            sign;
    logic            zero;
    logic            neg;
    bf16_t           packed_word;

    assign neg = (SIGNED != 0) && mag[IN_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (op_input_STB) state_nxt = ABS;
            ABS:     state_nxt = (mag == '0) ? PACK : NORM;
            NORM:    if (mag[IN_W-1]) state_nxt = PACK;
            PACK:    state_nxt = OUT;
            OUT:     if (!output_module_BUSY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mag      <= '0;
            exp      <= '0;
            sign     <= 1'b0;
            zero     <= 1'b0;
            output_x <= BF16_ZERO;
        end else begin
            case (state)
                IDLE: if (op_input_STB) mag <= input_int;
                ABS: begin
                    // Negating -2^(IN_W-1) yields 2^(IN_W-1) as an unsigned magnitude.
                    sign <= neg;
                    zero <= (mag == '0);
                    exp  <= EXP_INIT;
                    if (neg) mag <= -mag;
                end
                NORM: begin
                    if (!mag[IN_W-1]) begin
                        mag <= mag << 1;
                        exp <= exp - 8'd1;
                    end
                end
                PACK:    output_x <= zero ? BF16_ZERO : packed_word;
                default: ;
            endcase
        end
    end

    op_bf16_pack #(
        .IN_W(IN_W)
    ) u_pack (
        .mag (mag),
        .exp (exp),
        .sign(sign),
        .word(packed_word)
    );

    assign op_BUSY       = (state != IDLE);
    assign op_output_STB = (state == OUT);

endmodule
